id_ex_stage: RTL and testbench

- Pipeline register between instruction decode and execute in the pipelined MIPS datapath.
- Captures the control bundle from `control`, plus register-file operands, the sign-extended immediate, register indices and `funct` for the EX stage.
- Contains the load-use hazard detector. On a hazard it stalls PC/IF-ID and inserts a bubble.
- Accepts a flush from branch resolution, which squashes the instruction entering EX.

---
 rtl/id_ex_stage_if.sv | 64 ++++++
 rtl/id_ex_stage.sv | 89 ++++++++
 tb/tb_id_ex_stage.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_if.sv
// ID/EX pipeline bus: decoded ID-side fields and flush in; stall and the registered
// EX-side fields out.
interface id_ex_stage_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5
);
    logic              id_valid;
    logic              id_reg_dst;
    logic              id_alu_src;
    logic              id_mem_to_reg;
    logic              id_reg_write;
    logic              id_mem_read;
    logic              id_mem_write;
    logic              id_branch;
    logic              id_addi;
    logic [1:0]        id_alu_op;
    logic [DATA_W-1:0] id_pc4;
    logic [DATA_W-1:0] id_rs_data;
    logic [DATA_W-1:0] id_rt_data;
    logic [DATA_W-1:0] id_imm;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic [REG_AW-1:0] id_rd;
    logic [5:0]        id_funct;
    logic              flush;

    logic              stall;
    logic              ex_valid;
    logic              ex_reg_dst;
    logic              ex_alu_src;
    logic              ex_mem_to_reg;
    logic              ex_reg_write;
    logic              ex_mem_read;
    logic              ex_mem_write;
    logic              ex_branch;
    logic              ex_addi;
    logic [1:0]        ex_alu_op;
    logic [DATA_W-1:0] ex_pc4;
    logic [DATA_W-1:0] ex_rs_data;
    logic [DATA_W-1:0] ex_rt_data;
    logic [DATA_W-1:0] ex_imm;
    logic [REG_AW-1:0] ex_rs;
    logic [REG_AW-1:0] ex_rt;
    logic [REG_AW-1:0] ex_rd;
    logic [5:0]        ex_funct;

    modport master (
        output id_valid, id_reg_dst, id_alu_src, id_mem_to_reg, id_reg_write, id_mem_read,
               id_mem_write, id_branch, id_addi, id_alu_op, id_pc4, id_rs_data, id_rt_data,
               id_imm, id_rs, id_rt, id_rd, id_funct, flush,
        input  stall, ex_valid, ex_reg_dst, ex_alu_src, ex_mem_to_reg, ex_reg_write,
               ex_mem_read, ex_mem_write, ex_branch, ex_addi, ex_alu_op, ex_pc4, ex_rs_data,
               ex_rt_data, ex_imm, ex_rs, ex_rt, ex_rd, ex_funct
    );

    modport slave (
        input  id_valid, id_reg_dst, id_alu_src, id_mem_to_reg, id_reg_write, id_mem_read,
               id_mem_write, id_branch, id_addi, id_alu_op, id_pc4, id_rs_data, id_rt_data,
               id_imm, id_rs, id_rt, id_rd, id_funct, flush,
        output stall, ex_valid, ex_reg_dst, ex_alu_src, ex_mem_to_reg, ex_reg_write,
               ex_mem_read, ex_mem_write, ex_branch, ex_addi, ex_alu_op, ex_pc4, ex_rs_data,
               ex_rt_data, ex_imm, ex_rs, ex_rt, ex_rd, ex_funct
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and branch flush.
// Optional ID_EX_STALL_CNT_EN adds a saturating stall_cnt output.
module id_ex_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic        clk,
    input  logic        rst,
`ifdef ID_EX_STALL_CNT_EN
    output logic [31:0] stall_cnt,
`endif
    id_ex_stage_if.slave bus
);

    logic uses_rt;
    logic rs_match;
    logic rt_match;
    logic hazard;
    logic bubble;
    logic ctrl_en;

    // lw and addi write rt rather than read it, so only R-format, beq and sw count here.
    assign uses_rt  = bus.id_reg_dst | bus.id_branch | bus.id_mem_write;
    assign rs_match = (bus.ex_rt == bus.id_rs);
    assign rt_match = uses_rt & (bus.ex_rt == bus.id_rt);

    always_comb begin
        hazard = bus.ex_valid & bus.ex_mem_read & (bus.ex_rt != {REG_AW{1'b0}}) &
                 (rs_match | rt_match) & bus.id_valid;
    end

    assign bus.stall = hazard & ~bus.flush & ~rst;
    assign bubble    = bus.flush | hazard;
    assign ctrl_en   = bus.id_valid;

    always_ff @(posedge clk) begin
        if (rst || bubble) begin
            bus.ex_valid      <= 1'b0;
            bus.ex_reg_dst    <= 1'b0;
            bus.ex_alu_src    <= 1'b0;
            bus.ex_mem_to_reg <= 1'b0;
            bus.ex_reg_write  <= 1'b0;
            bus.ex_mem_read   <= 1'b0;
            bus.ex_mem_write  <= 1'b0;
            bus.ex_branch     <= 1'b0;
            bus.ex_addi       <= 1'b0;
            bus.ex_alu_op     <= 2'b00;
            bus.ex_pc4        <= {DATA_W{1'b0}};
            bus.ex_rs_data    <= {DATA_W{1'b0}};
            bus.ex_rt_data    <= {DATA_W{1'b0}};
            bus.ex_imm        <= {DATA_W{1'b0}};
            bus.ex_rs         <= {REG_AW{1'b0}};
            bus.ex_rt         <= {REG_AW{1'b0}};
            bus.ex_rd         <= {REG_AW{1'b0}};
            bus.ex_funct      <= 6'd0;
        end else begin
            bus.ex_valid      <= bus.id_valid;
            // An invalid ID slot still moves its data but never its side effects.
            bus.ex_reg_dst    <= bus.id_reg_dst & ctrl_en;
            bus.ex_alu_src    <= bus.id_alu_src & ctrl_en;
            bus.ex_mem_to_reg <= bus.id_mem_to_reg & ctrl_en;
            bus.ex_reg_write  <= bus.id_reg_write & ctrl_en;
            bus.ex_mem_read   <= bus.id_mem_read & ctrl_en;
            bus.ex_mem_write  <= bus.id_mem_write & ctrl_en;
            bus.ex_branch     <= bus.id_branch & ctrl_en;
            bus.ex_addi       <= bus.id_addi & ctrl_en;
            bus.ex_alu_op     <= bus.id_alu_op & {2{ctrl_en}};
            bus.ex_pc4        <= bus.id_pc4;
            bus.ex_rs_data    <= bus.id_rs_data;
            bus.ex_rt_data    <= bus.id_rt_data;
            bus.ex_imm        <= bus.id_imm;
            bus.ex_rs         <= bus.id_rs;
            bus.ex_rt         <= bus.id_rt;
            bus.ex_rd         <= bus.id_rd;
            bus.ex_funct      <= bus.id_funct;
        end
    end

`ifdef ID_EX_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= 32'd0;
        end else if (bus.stall && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed vector table plus randomized traffic
// against a slot-level reference model.
module tb_id_ex_stage;

    localparam logic [7:0] C_R    = 8'b1001_0000;
    localparam logic [7:0] C_LW   = 8'b0111_1000;
    localparam logic [7:0] C_SW   = 8'b0100_0100;
    localparam logic [7:0] C_ADDI = 8'b0001_0001;
    localparam logic [7:0] C_BR   = 8'b0000_0010;

    // ctrl: [7]reg_dst [6]alu_src [5]mem_to_reg [4]reg_write [3]mem_read [2]mem_write
    //       [1]branch [0]addi
    typedef struct packed {
        logic        valid;
        logic [7:0]  ctrl;
        logic [1:0]  alu_op;
        logic [31:0] pc4;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [5:0]  funct;
    } slot_t;

    typedef struct {
        logic  rst;
        logic  flush;
        slot_t id;
        logic  exp_stall;
        logic  exp_valid;
        logic  exp_reg_write;
        logic  exp_mem_read;
        logic  exp_mem_write;
    } vec_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    slot_t model_ex;
    logic [31:0] model_cnt;
    vec_t vecs[$];

    id_ex_stage_if #(.DATA_W(32), .REG_AW(5)) bus ();

`ifdef ID_EX_STALL_CNT_EN
    logic [31:0] stall_cnt;
    id_ex_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .stall_cnt (stall_cnt),
        .bus       (bus.slave)
    );
`else
    id_ex_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic slot_t mk(input logic valid, input logic [7:0] ctrl,
                                 input logic [1:0] alu_op, input logic [4:0] rs,
                                 input logic [4:0] rt, input logic [4:0] rd,
                                 input logic [31:0] imm, input logic [5:0] funct);
        slot_t s;
        s.valid   = valid;
        s.ctrl    = ctrl;
        s.alu_op  = alu_op;
        s.pc4     = $urandom;
        s.rs_data = $urandom;
        s.rt_data = $urandom;
        s.imm     = imm;
        s.rs      = rs;
        s.rt      = rt;
        s.rd      = rd;
        s.funct   = funct;
        return s;
    endfunction

    // A load in EX whose destination is read by the valid ID instruction.
    function automatic logic model_hazard(input slot_t ex, input slot_t id);
        logic reads_rt;
        reads_rt = id.ctrl[7] | id.ctrl[1] | id.ctrl[2];
        return id.valid && ex.valid && ex.ctrl[3] && (ex.rt != 5'd0) &&
               ((ex.rt == id.rs) || (reads_rt && (ex.rt == id.rt)));
    endfunction

    function automatic slot_t model_next(input slot_t ex, input slot_t id, input logic r,
                                         input logic fl);
        slot_t n;
        if (r || fl || model_hazard(ex, id)) return '0;
        n = id;
        if (!id.valid) begin
            n.ctrl   = 8'd0;
            n.alu_op = 2'd0;
        end
        return n;
    endfunction

    function automatic slot_t dut_slot();
        slot_t s;
        s.valid   = bus.ex_valid;
        s.ctrl    = {bus.ex_reg_dst, bus.ex_alu_src, bus.ex_mem_to_reg, bus.ex_reg_write,
                     bus.ex_mem_read, bus.ex_mem_write, bus.ex_branch, bus.ex_addi};
        s.alu_op  = bus.ex_alu_op;
        s.pc4     = bus.ex_pc4;
        s.rs_data = bus.ex_rs_data;
        s.rt_data = bus.ex_rt_data;
        s.imm     = bus.ex_imm;
        s.rs      = bus.ex_rs;
        s.rt      = bus.ex_rt;
        s.rd      = bus.ex_rd;
        s.funct   = bus.ex_funct;
        return s;
    endfunction

    task automatic check_bit(input string name, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic check_word(input string name, input logic [31:0] got,
                              input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check_slot(input string name, input slot_t got, input slot_t exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input slot_t id, input logic r, input logic fl);
        rst               = r;
        bus.flush         = fl;
        bus.id_valid      = id.valid;
        bus.id_reg_dst    = id.ctrl[7];
        bus.id_alu_src    = id.ctrl[6];
        bus.id_mem_to_reg = id.ctrl[5];
        bus.id_reg_write  = id.ctrl[4];
        bus.id_mem_read   = id.ctrl[3];
        bus.id_mem_write  = id.ctrl[2];
        bus.id_branch     = id.ctrl[1];
        bus.id_addi       = id.ctrl[0];
        bus.id_alu_op     = id.alu_op;
        bus.id_pc4        = id.pc4;
        bus.id_rs_data    = id.rs_data;
        bus.id_rt_data    = id.rt_data;
        bus.id_imm        = id.imm;
        bus.id_rs         = id.rs;
        bus.id_rt         = id.rt;
        bus.id_rd         = id.rd;
        bus.id_funct      = id.funct;
    endtask

    // Drive one cycle, check stall before the edge and the EX slot after it.
    task automatic step(input slot_t id, input logic r, input logic fl, output logic got_stall);
        logic  exp_stall;
        slot_t nxt;
        drive(id, r, fl);
        #1;
        exp_stall = model_hazard(model_ex, id) & ~fl & ~r;
        check_bit("stall", bus.stall, exp_stall);
        got_stall = bus.stall;
        nxt = model_next(model_ex, id, r, fl);
        if (r) model_cnt = 32'd0;
        else if (exp_stall && model_cnt != 32'hFFFF_FFFF) model_cnt = model_cnt + 32'd1;
        @(posedge clk);
        #1;
        model_ex = nxt;
        check_slot("ex_slot", dut_slot(), model_ex);
`ifdef ID_EX_STALL_CNT_EN
        check_word("stall_cnt_model", stall_cnt, model_cnt);
`endif
    endtask

    task automatic add_vec(input logic r, input logic fl, input slot_t id, input logic s,
                           input logic v, input logic rw, input logic mr, input logic mw);
        vec_t x;
        x.rst = r; x.flush = fl; x.id = id;
        x.exp_stall = s; x.exp_valid = v; x.exp_reg_write = rw;
        x.exp_mem_read = mr; x.exp_mem_write = mw;
        vecs.push_back(x);
    endtask

    task automatic run_vecs();
        logic s;
        foreach (vecs[i]) begin
            step(vecs[i].id, vecs[i].rst, vecs[i].flush, s);
            check_bit("vec_stall", s, vecs[i].exp_stall);
            check_bit("vec_valid", bus.ex_valid, vecs[i].exp_valid);
            check_bit("vec_reg_write", bus.ex_reg_write, vecs[i].exp_reg_write);
            check_bit("vec_mem_read", bus.ex_mem_read, vecs[i].exp_mem_read);
            check_bit("vec_mem_write", bus.ex_mem_write, vecs[i].exp_mem_write);
        end
        vecs.delete();
    endtask

    function automatic logic [4:0] pick_reg();
        case ($urandom_range(0, 3))
            0:       return 5'd0;
            1:       return 5'd8;
            2:       return 5'd9;
            default: return 5'($urandom);
        endcase
    endfunction

    function automatic logic [7:0] pick_ctrl();
        case ($urandom_range(0, 5))
            0:       return C_R;
            1:       return C_LW;
            2:       return C_SW;
            3:       return C_ADDI;
            4:       return C_BR;
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        logic s;
        slot_t id;
        n_checks  = 0;
        n_fail    = 0;
        model_ex  = '0;
        model_cnt = 32'd0;
        rst       = 1'b1;
        drive('0, 1'b1, 1'b0);
        #2;

        // Reset with live inputs, then the basic pass-through and load-use sequences.
        add_vec(1, 0, mk(1, C_R, 2, 9, 8, 10, 0, 6'h20), 0, 0, 0, 0, 0);
        add_vec(1, 0, mk(1, C_LW, 0, 8, 9, 0, 4, 0), 0, 0, 0, 0, 0);
        add_vec(0, 0, mk(1, C_ADDI, 0, 8, 9, 0, 5, 0), 0, 1, 1, 0, 0);
        add_vec(0, 0, mk(1, C_LW, 0, 8, 9, 0, 4, 0), 0, 1, 1, 1, 0);
        add_vec(0, 0, mk(1, C_R, 2, 9, 8, 10, 0, 6'h20), 1, 0, 0, 0, 0);
        add_vec(0, 0, mk(1, C_R, 2, 9, 8, 10, 0, 6'h20), 0, 1, 1, 0, 0);
        add_vec(0, 0, mk(1, C_LW, 0, 8, 0, 0, 4, 0), 0, 1, 1, 1, 0);
        add_vec(0, 0, mk(1, C_R, 2, 0, 0, 11, 0, 6'h20), 0, 1, 1, 0, 0);
        add_vec(0, 0, mk(1, C_LW, 0, 8, 9, 0, 4, 0), 0, 1, 1, 1, 0);
        add_vec(0, 0, mk(1, C_ADDI, 0, 8, 9, 0, 7, 0), 0, 1, 1, 0, 0);
        add_vec(0, 0, mk(1, C_LW, 0, 8, 9, 0, 4, 0), 0, 1, 1, 1, 0);
        add_vec(0, 1, mk(1, C_SW, 0, 8, 9, 0, 8, 0), 0, 0, 0, 0, 0);
        add_vec(0, 0, mk(0, C_LW, 0, 8, 9, 0, 4, 0), 0, 0, 0, 0, 0);
        add_vec(0, 0, mk(1, C_LW, 0, 8, 9, 0, 4, 0), 0, 1, 1, 1, 0);
        add_vec(0, 0, mk(1, C_BR, 1, 1, 9, 0, 3, 0), 1, 0, 0, 0, 0);
        add_vec(0, 0, mk(1, C_BR, 1, 1, 9, 0, 3, 0), 0, 1, 0, 0, 0);
        add_vec(0, 0, mk(1, C_LW, 0, 8, 9, 0, 4, 0), 0, 1, 1, 1, 0);
        add_vec(0, 0, mk(1, C_SW, 0, 8, 9, 0, 8, 0), 1, 0, 0, 0, 0);
        add_vec(0, 0, mk(1, C_SW, 0, 8, 9, 0, 8, 0), 0, 1, 0, 0, 1);
        run_vecs();
`ifdef ID_EX_STALL_CNT_EN
        check_word("stall_cnt_three", stall_cnt, 32'd3);
`endif

        // Reset arriving while a load-use stall is pending.
        add_vec(0, 0, mk(1, C_LW, 0, 8, 9, 0, 4, 0), 0, 1, 1, 1, 0);
        add_vec(1, 0, mk(1, C_R, 2, 9, 8, 10, 0, 6'h20), 0, 0, 0, 0, 0);
        run_vecs();
`ifdef ID_EX_STALL_CNT_EN
        check_word("stall_cnt_reset", stall_cnt, 32'd0);
`endif

        for (int i = 0; i < 500; i++) begin
            id = mk(($urandom_range(0, 9) != 0), pick_ctrl(), 2'($urandom), pick_reg(),
                    pick_reg(), pick_reg(), $urandom, 6'($urandom));
            step(id, ($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0), s);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
